// File: rtl/enc4x2_pkg.sv
// Shared types for the 4-to-2 priority encoder pipeline.
package enc4x2_pkg;

  localparam int CODE_W = 2;

  // Skid-buffer occupancy
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_e;

  // One stored result: encoded index plus not-one-hot flag
  typedef struct packed {
    logic [CODE_W-1:0] code;
    logic              err;
  } ent_t;

endpackage

// File: rtl/enc4x2_prio.sv
// Combinational highest-bit-wins encoder with not-one-hot detection.
module enc4x2_prio
  import enc4x2_pkg::*;
(
  input  logic [3:0]        in,
  output logic [CODE_W-1:0] code,
  output logic              err
);

  // Priority encode; an all-zero word encodes as 0
  always_comb begin
    code = '0;
    casez (in)
      4'b1???: code = 2'd3;
      4'b01??: code = 2'd2;
      4'b001?: code = 2'd1;
      default: code = 2'd0;
    endcase
  end

  // x & (x-1) clears the lowest set bit, so nonzero means two or more bits set
  always_comb begin
    err = (in == 4'd0) | (|(in & (in - 4'd1)));
  end

endmodule

// File: rtl/enc4x2_pipe.sv
// Priority encoder behind a 2-entry skid buffer with saturating delivery stats.
module enc4x2_pipe
  import enc4x2_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_onehot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_err,
  input  logic              clr_cnt,
  output logic [CNT_W-1:0]  word_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  occ_e             state_q, state_d;
  ent_t             head_q, head_d;   // oldest word, drives the outputs
  ent_t             tail_q, tail_d;   // second word, only valid in TWO
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  ent_t             new_ent;
  logic             acc, drn;

  enc4x2_prio u_prio (
    .in   (in_onehot),
    .code (new_ent.code),
    .err  (new_ent.err)
  );

  assign acc = in_valid & in_ready_q;
  assign drn = out_valid_q & out_ready;

  // Occupancy transitions and entry movement; ready/valid are re-derived from
  // the next state so both leave the block straight from flops
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      EMPTY: if (acc) begin
        head_d  = new_ent;
        state_d = ONE;
      end
      ONE: begin
        if (acc && drn)  head_d = new_ent;
        else if (acc)    begin tail_d = new_ent; state_d = TWO; end
        else if (drn)    state_d = EMPTY;
      end
      TWO: if (drn) begin
        head_d  = tail_q;
        state_d = ONE;
      end
      default: state_d = EMPTY;
    endcase
    in_ready_d  = (state_d != TWO);
    out_valid_d = (state_d != EMPTY);
  end

  // Saturating statistics; clear wins over a same-cycle delivery
  always_comb begin
    word_cnt_d = word_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = '0;
      err_cnt_d  = '0;
    end else if (drn) begin
      if (word_cnt_q != CNT_MAX)              word_cnt_d = word_cnt_q + 1'b1;
      if (head_q.err && err_cnt_q != CNT_MAX) err_cnt_d  = err_cnt_q + 1'b1;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= EMPTY;
      head_q      <= '0;
      tail_q      <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      word_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      word_cnt_q  <= word_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_code  = head_q.code;
  assign out_err   = head_q.err;
  assign word_cnt  = word_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: doc/enc4x2_pipe.md
ENC4X2_PIPE -- requirements
Module: enc4x2_pipe

Interface
REQ-001 Parameter CNT_W, default 8: width of the statistics counters, legal range 2..32.
REQ-002 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-004 Port in_valid  input  1: upstream word present.
REQ-005 Port in_ready  output  1: block can accept a word this cycle.
REQ-006 Port in_onehot  input  4: word to encode, intended one-hot.
REQ-007 Port out_valid  output  1: encoded word present.
REQ-008 Port out_ready  input  1: downstream accepts the word this cycle.
REQ-009 Port out_code  output  2: binary index of the highest set bit of the accepted word.
REQ-010 Port out_err  output  1: accepted word was not exactly one-hot.
REQ-011 Port clr_cnt  input  1: synchronous clear of both counters.
REQ-012 Port word_cnt  output  CNT_W: words delivered downstream, saturating.
REQ-013 Port err_cnt  output  CNT_W: delivered words with out_err=1, saturating.

Function
REQ-014 Input transfer SHALL occur when in_valid and in_ready are both 1 on a rising edge; output transfer SHALL occur when out_valid and out_ready are both 1.
REQ-015 Encoding SHALL be priority, highest bit wins: 1xxx->3, 01xx->2, 001x->1, 0001->0, 0000->0.
REQ-016 out_err SHALL be 1 for 0000 and for any word with two or more bits set; otherwise 0.
REQ-017 Code and error SHALL be computed at acceptance and stored; out_code and out_err SHALL come directly from registers.
REQ-018 Storage SHALL be a 2-entry skid buffer with occupancy FSM states EMPTY, ONE, TWO.
REQ-019 EMPTY: accept -> ONE; no accept -> EMPTY.
REQ-020 ONE: accept without drain -> TWO; drain without accept -> EMPTY; accept with drain, or neither -> ONE.
REQ-021 TWO: drain -> ONE; no drain -> TWO; no input is accepted in TWO.
REQ-022 in_ready SHALL be 1 in EMPTY and ONE, 0 in TWO, and SHALL come directly from a register (no combinational path from out_ready).
REQ-023 out_valid SHALL be 1 in ONE and TWO; out_code and out_err SHALL show the oldest stored word.
REQ-024 Latency: a word accepted at edge N SHALL be on the outputs with out_valid=1 after edge N when the buffer was EMPTY.
REQ-025 Order SHALL be preserved; no word is dropped or duplicated under any out_ready pattern.
REQ-026 While out_valid=1 and out_ready=0, out_code and out_err SHALL stay stable.
REQ-027 word_cnt SHALL increment by 1 on each output transfer; err_cnt SHALL increment by 1 on each output transfer with out_err=1.
REQ-028 Each counter SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-029 clr_cnt=1 SHALL set both counters to 0 at the next edge, with priority over a same-cycle increment; buffer contents are unaffected.

Reset
REQ-030 rst_n=0 SHALL immediately force state EMPTY, in_ready=0, out_valid=0, out_code=0, out_err=0, word_cnt=0, err_cnt=0.
REQ-031 in_ready SHALL become 1 on the first rising edge after rst_n deasserts.
REQ-032 Reset during a transfer SHALL discard all stored words; no output transfer completes in that cycle.

Structure
REQ-033 A shared package SHALL hold the FSM state enumeration (EMPTY, ONE, TWO) and the code-width constant (2).
REQ-034 Combinational priority encoding and error detection SHALL be a sub-module named enc4x2_prio (in 4, code 2, err 1), instantiated once at the input.

Verification
REQ-035 Stream 0001, 0010, 0100, 1000 with out_ready=1 -> codes 0, 1, 2, 3, err=0, one cycle after each input; word_cnt=4.
REQ-036 Send 0000, then 0110, then 1111 -> code/err 0/1, 2/1, 3/1; err_cnt=3.
REQ-037 Hold out_ready=0 and offer three words -> two accepted, in_ready=0 from the edge after the second acceptance; outputs stable. Release out_ready -> words emerge in order, then the third is accepted.
REQ-038 Random in_valid/out_ready toggling over 1000 words -> output sequence matches a reference queue with no loss or duplication; in_ready never 1 in TWO.
REQ-039 CNT_W=2: deliver 5 words -> word_cnt stops at 3. Assert clr_cnt in the same cycle as a delivery -> word_cnt=0.
REQ-040 Assert rst_n=0 mid-stream with TWO occupied -> out_valid=0 and counters 0 at once. After deassertion -> the next word has 1-cycle latency.
